// File: rtl/noc_config_pkg.sv
// Shared NoC configuration, flit format, lock-state encoding and credit sizing helper.
package noc_config_pkg;

    localparam int NOC_VC_IDX_W = 4;
    localparam int NOC_DATA_W   = 32;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned input_fifo_depth;
    } noc_config_t;

    localparam noc_config_t NOC_DEFAULT_CONFIG = '{virtual_channels: 2, input_fifo_depth: 8};

    typedef struct packed {
        logic                    head;
        logic                    tail;
        logic [NOC_VC_IDX_W-1:0] vc;
        logic [NOC_DATA_W-1:0]   data;
    } noc_flit_t;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // A counter spanning 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_flit_if.sv
// Flit link. Handshake: a flit moves on a cycle where valid and ready are both high;
// once valid is raised the initiator holds valid and flit stable until that cycle.
interface noc_flit_if;
    import noc_config_pkg::*;

    logic      valid;
    logic      ready;
    noc_flit_t flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream VC FIFO: starts full, spends on send, refills on return.
module noc_credit_counter
    import noc_config_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = credit_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_dec,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_error
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= FULL;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        count_d = count_q;
        error_d = error_q;
        if (i_dec && !i_inc) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end else if (i_inc && !i_dec) begin
            // A return with nothing outstanding means the receiver miscounted.
            if (count_q == FULL) error_d = 1'b1;
            else                 count_d = count_q + 1'b1;
        end
        if (i_clear) begin
            count_d = FULL;
            error_d = 1'b0;
        end
    end

    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_error = error_q;

endmodule

// File: rtl/noc_vc_credit_transmitter.sv
// Merges per-VC flit sources onto one link with credit flow control, round-robin
// arbitration and packet locking so a packet's flits stay contiguous.
module noc_vc_credit_transmitter
    import noc_config_pkg::*;
#(
    parameter noc_config_t CONFIG = NOC_DEFAULT_CONFIG,
    localparam int CHANNELS = int'(CONFIG.virtual_channels),
    localparam int DEPTH    = int'(CONFIG.input_fifo_depth),
    localparam int CW       = credit_width(DEPTH),
    localparam int PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic [CHANNELS-1:0]          i_credit_return,
    output logic [CHANNELS-1:0]          o_credit_empty,
    output logic                         o_credit_error,
    noc_flit_if.target                   flit_in_if [CHANNELS],
    noc_flit_if.initiator                flit_out_if,
    output lock_state_e                  o_dbg_lock_state,
    output logic [PTR_W-1:0]             o_dbg_ptr,
    output logic [CHANNELS-1:0][CW-1:0]  o_dbg_credit
);

    logic [CHANNELS-1:0]         in_valid, in_ready, eligible, accept_vec, cnt_error;
    noc_flit_t [CHANNELS-1:0]    in_flit;
    logic [CHANNELS-1:0][CW-1:0] credit;

    lock_state_e      state_q, state_d;
    logic [PTR_W-1:0] lock_idx_q, lock_idx_d, ptr_q, ptr_d, hold_idx_q, hold_idx_d;
    logic             hold_q, hold_d;

    logic [PTR_W-1:0] rr_idx, gnt;
    logic             rr_found, gnt_valid, out_valid, accept;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
        assign in_valid[i]         = flit_in_if[i].valid;
        assign in_flit[i]          = flit_in_if[i].flit;
        assign flit_in_if[i].ready = in_ready[i];
        assign eligible[i]         = in_valid[i] && (credit[i] != '0);
        assign accept_vec[i]       = accept && (gnt == PTR_W'(i));

        noc_credit_counter #(.DEPTH(DEPTH), .CW(CW)) u_credit (
            .clk     (clk),
            .rst     (rst),
            .i_clear (i_clear),
            .i_dec   (accept_vec[i]),
            .i_inc   (i_credit_return[i]),
            .o_count (credit[i]),
            .o_empty (o_credit_empty[i]),
            .o_error (cnt_error[i])
        );
    end

    assign o_credit_error   = |cnt_error;
    assign o_dbg_lock_state = state_q;
    assign o_dbg_ptr        = ptr_q;
    assign o_dbg_credit     = credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCK_IDLE;
            lock_idx_q <= '0;
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // Round-robin search starting at the priority pointer.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'(idx);
            end
        end
    end

    // A stalled offer keeps its grant; a locked packet owns the link.
    always_comb begin
        gnt       = rr_idx;
        gnt_valid = rr_found;
        if (hold_q) begin
            gnt       = hold_idx_q;
            gnt_valid = 1'b1;
        end else if (state_q == LOCK_LOCKED) begin
            gnt       = lock_idx_q;
            gnt_valid = 1'b1;
        end
        out_valid          = gnt_valid && eligible[gnt];
        accept             = out_valid && flit_out_if.ready;
        in_ready           = '0;
        in_ready[gnt]      = out_valid && flit_out_if.ready;
        flit_out_if.valid  = out_valid;
        flit_out_if.flit    = in_flit[gnt];
        flit_out_if.flit.vc = NOC_VC_IDX_W'(gnt);
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        hold_d     = out_valid;
        hold_idx_d = gnt;
        if (accept) begin
            hold_d = 1'b0;
            if (in_flit[gnt].tail) begin
                state_d = LOCK_IDLE;
                ptr_d   = (int'(gnt) + 1 >= CHANNELS) ? '0 : gnt + 1'b1;
            end else if (in_flit[gnt].head) begin
                state_d    = LOCK_LOCKED;
                lock_idx_d = gnt;
            end
        end
        if (i_clear) begin
            state_d    = LOCK_IDLE;
            lock_idx_d = '0;
            ptr_d      = '0;
            hold_d     = 1'b0;
            hold_idx_d = '0;
        end
    end

endmodule

// File: doc/noc_vc_credit_transmitter.md
NOC_VC_CREDIT_TRANSMITTER -- requirements
Module: noc_vc_credit_transmitter

Interface
REQ-001 SHALL have parameter CONFIG, default NOC_DEFAULT_CONFIG, giving the NoC configuration.
REQ-002 SHALL derive localparam CHANNELS = CONFIG.virtual_channels, the number of virtual channels.
REQ-003 SHALL derive localparam DEPTH = CONFIG.input_fifo_depth, the receiver FIFO depth per VC and the initial credit count.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 i_clear  input  1  synchronous soft clear.
REQ-008 i_credit_return  input  CHANNELS  bit i pulse = one slot freed in downstream VC i FIFO.
REQ-009 o_credit_empty  output  CHANNELS  bit i high when VC i credit count = 0.
REQ-010 o_credit_error  output  1  sticky flag: credit returned while count already DEPTH.
REQ-011 flit_in_if  noc_flit_if.target  array[CHANNELS]  per-VC flit sources.
REQ-012 flit_out_if  noc_flit_if.initiator  1  merged link; flit carries its VC index.

Function
REQ-013 SHALL keep one credit counter per VC, width clog2(DEPTH+1), value range 0..DEPTH.
REQ-014 Counter SHALL decrement by 1 on each flit accepted on VC i (out valid & ready, granted VC i).
REQ-015 Counter SHALL increment by 1 on i_credit_return[i]; simultaneous accept and return SHALL leave it unchanged.
REQ-016 Return at count = DEPTH without a same-cycle accept SHALL hold the count at DEPTH and set o_credit_error until reset/clear.
REQ-017 VC i is eligible when flit_in_if[i] valid and credit[i] > 0.
REQ-018 Arbitration SHALL be round-robin over eligible VCs, starting from the priority pointer.
REQ-019 Lock FSM states IDLE and LOCKED; IDLE->LOCKED on accepting a head flit without tail; LOCKED->IDLE on accepting the tail flit.
REQ-020 In LOCKED, only the locked VC is eligible; other VCs SHALL NOT be granted, even with credit.
REQ-021 A head+tail single-flit packet SHALL leave the FSM in IDLE.
REQ-022 Priority pointer SHALL advance to (granted VC + 1) mod CHANNELS on tail acceptance.
REQ-023 Once out valid is asserted and not accepted, grant and flit SHALL hold stable until acceptance.
REQ-024 Out valid = granted VC valid & credit > 0; flit_in_if[g].ready = flit_out_if.ready & grant g; zero-cycle latency.
REQ-025 Output flit VC field SHALL equal granted VC index; other fields pass unmodified.
REQ-026 No flit SHALL be sent on a VC with credit 0; credit returns SHALL never be lost.
REQ-027 i_clear SHALL set credits to DEPTH, FSM to IDLE, pointer to 0, o_credit_error to 0, next cycle.

Reset
REQ-028 On rst: credits = DEPTH, FSM IDLE, pointer 0, o_credit_error 0, o_credit_empty all 0, out valid 0.
REQ-029 Reset mid-packet SHALL abandon the lock; no partial-packet recovery.

Structure
REQ-030 Lock-state enum and credit-width function SHALL live in noc_config_pkg.
REQ-031 Per-VC credit counter SHALL be sub-module noc_credit_counter, instanced CHANNELS times in a generate loop.
REQ-032 Arbiter and lock FSM SHALL reside in the top module.

Verification (CHANNELS=2, DEPTH=8)
REQ-033 Send 8 single-flit packets on VC0, no returns -> 8 accepted, o_credit_empty[0]=1, VC0 ready low thereafter; one return -> exactly one more flit.
REQ-034 VC0 and VC1 continuously valid, single-flit packets, out ready=1 -> output VC alternates 0,1,0,1.
REQ-035 VC0 4-flit packet, VC1 valid throughout -> all 4 VC0 flits contiguous before any VC1 flit.
REQ-036 VC0 locked mid-packet at credit 0, VC1 valid -> out valid low, no VC1 grant until VC0 credit returns.
REQ-037 Accept on VC1 and return on VC1 in the same cycle at count 5 -> count stays 5; return at count 8 -> o_credit_error=1.
REQ-038 Assert rst then i_clear mid-packet -> credits 8, FSM IDLE, pointer 0, o_credit_error 0.
